// File: rtl/led_array_sequencer.sv
// Serial-addressed LED array sequencer: 3-wire frame loader, per-channel mode registers,
// internal blink and PWM generation, registered LED drive.
module led_array_sequencer #(
    parameter int N_LEDS    = 20,
    parameter int ADDR_W    = 5,
    parameter int MODE_W    = 3,
    parameter int BLINK_DIV = 1000000,
    parameter int PWM_DIV   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCLK,
    input  logic              DATA,
    input  logic              LATCH,
    output logic [N_LEDS-1:0] LED,
    output logic              FRAME_ERR
);

    localparam int FRAME_W = MODE_W + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [ADDR_W-1:0] ADDR_BCAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_BRIGHT = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(FRAME_W + 1);

    logic sclkMeta_q, sclkSync_q, sclkPrev_q;
    logic dataMeta_q, dataSync_q;
    logic latchMeta_q, latchSync_q, latchPrev_q;
    logic sclkRise, latchRise;

    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [MODE_W-1:0]  mode_q [N_LEDS];
    logic [MODE_W-1:0]  mode_d [N_LEDS];
    logic [MODE_W-1:0]  bright_q, bright_d;
    logic               frameErr_q, frameErr_d;

    logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
    logic               blinkA_q, blinkA_d, blinkB_q, blinkB_d, blinkWrap;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [MODE_W-1:0]  pwmCnt_q, pwmCnt_d;
    logic               preWrap, pwmOn;
    logic [N_LEDS-1:0]  led_q, led_d;

    logic [ADDR_W-1:0]  frameAddr;
    logic [MODE_W-1:0]  frameField;
    logic               addrIsLed;

    assign sclkRise   = sclkSync_q & ~sclkPrev_q;
    assign latchRise  = latchSync_q & ~latchPrev_q;
    assign frameAddr  = shift_q[ADDR_W-1:0];
    assign frameField = shift_q[FRAME_W-1:ADDR_W];
    assign addrIsLed  = (32'(frameAddr) < N_LEDS);

    // A LATCH rise takes priority: any SCLK rise seen in the same cycle is dropped.
    always_comb begin
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        mode_d     = mode_q;
        bright_d   = bright_q;
        frameErr_d = 1'b0;
        if (latchRise) begin
            bitCnt_d = '0;
            if (bitCnt_q != CNT_FULL) begin
                frameErr_d = 1'b1;
            end else if (addrIsLed) begin
                for (int i = 0; i < N_LEDS; i++) begin
                    if (frameAddr == ADDR_W'(i)) mode_d[i] = frameField;
                end
            end else if (frameAddr == ADDR_BCAST) begin
                for (int i = 0; i < N_LEDS; i++) mode_d[i] = frameField;
            end else if (frameAddr == ADDR_BRIGHT) begin
                bright_d = frameField;
            end else begin
                frameErr_d = 1'b1;
            end
        end else if (sclkRise && !latchSync_q) begin
            shift_d = {shift_q[FRAME_W-2:0], dataSync_q};
            if (bitCnt_q != CNT_SAT) bitCnt_d = bitCnt_q + CNT_W'(1);
        end
    end

    // blink_b toggles only on wraps that take blink_a from 0 to 1.
    always_comb begin
        blinkWrap  = (blinkCnt_q == BLINK_W'(BLINK_DIV - 1));
        blinkCnt_d = blinkWrap ? '0 : blinkCnt_q + BLINK_W'(1);
        blinkA_d   = blinkA_q ^ blinkWrap;
        blinkB_d   = blinkB_q ^ (blinkWrap & ~blinkA_q);
        preWrap    = (pre_q == PRE_W'(PWM_DIV - 1));
        pre_d      = preWrap ? '0 : pre_q + PRE_W'(1);
        pwmCnt_d   = preWrap ? pwmCnt_q + MODE_W'(1) : pwmCnt_q;
        pwmOn      = (pwmCnt_q <= bright_q);
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (32'(mode_q[i]))
                1:       led_d[i] = pwmOn;
                2:       led_d[i] = pwmOn & blinkA_q;
                3:       led_d[i] = pwmOn & blinkB_q;
                4:       led_d[i] = pwmOn & ~blinkA_q;
                default: led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclkMeta_q  <= 1'b0;
            sclkSync_q  <= 1'b0;
            sclkPrev_q  <= 1'b0;
            dataMeta_q  <= 1'b0;
            dataSync_q  <= 1'b0;
            latchMeta_q <= 1'b0;
            latchSync_q <= 1'b0;
            latchPrev_q <= 1'b0;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            for (int i = 0; i < N_LEDS; i++) mode_q[i] <= '0;
            bright_q    <= '1;
            frameErr_q  <= 1'b0;
            blinkCnt_q  <= '0;
            blinkA_q    <= 1'b0;
            blinkB_q    <= 1'b0;
            pre_q       <= '0;
            pwmCnt_q    <= '0;
            led_q       <= '0;
        end else begin
            sclkMeta_q  <= SCLK;
            sclkSync_q  <= sclkMeta_q;
            sclkPrev_q  <= sclkSync_q;
            dataMeta_q  <= DATA;
            dataSync_q  <= dataMeta_q;
            latchMeta_q <= LATCH;
            latchSync_q <= latchMeta_q;
            latchPrev_q <= latchSync_q;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            mode_q      <= mode_d;
            bright_q    <= bright_d;
            frameErr_q  <= frameErr_d;
            blinkCnt_q  <= blinkCnt_d;
            blinkA_q    <= blinkA_d;
            blinkB_q    <= blinkB_d;
            pre_q       <= pre_d;
            pwmCnt_q    <= pwmCnt_d;
            led_q       <= led_d;
        end
    end

    assign LED       = led_q;
    assign FRAME_ERR = frameErr_q;

endmodule

// File: tb/tb_led_array_sequencer.sv
// Directed bench for led_array_sequencer with BLINK_DIV=8, PWM_DIV=1.
module tb_led_array_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SCLK = 1'b0;
    logic        DATA = 1'b0;
    logic        LATCH = 1'b0;
    logic [19:0] LED;
    logic        FRAME_ERR;

    int vectors = 0;
    int miscompares = 0;
    int errCount = 0;
    int cyc = 0;

    led_array_sequencer #(
        .N_LEDS(20), .ADDR_W(5), .MODE_W(3), .BLINK_DIV(8), .PWM_DIV(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .DATA(DATA), .LATCH(LATCH),
        .LED(LED), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // cyc = number of clock edges since the last reset edge.
    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Every cycle FRAME_ERR is high counts once, so a stretched pulse shows up too.
    always @(negedge CLK) begin
        if (FRAME_ERR === 1'b1) errCount <= errCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Blink state after j edges from reset: A flips every 8 edges, B on A's 0->1 flips.
    function automatic logic bA(input int j);
        return ((j / 8) % 2) == 1;
    endfunction

    function automatic logic bB(input int j);
        return (((j + 8) / 16) % 2) == 1;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic shiftBits(input logic [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            DATA = val[i];
            waitCycles(4);
            SCLK = 1'b1;
            waitCycles(4);
            SCLK = 1'b0;
        end
        waitCycles(4);
    endtask

    task automatic latchFrame();
        LATCH = 1'b1;
        waitCycles(4);
        LATCH = 1'b0;
        waitCycles(4);
    endtask

    task automatic sendFrame(input logic [15:0] val, input int n);
        shiftBits(val, n);
        latchFrame();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        waitCycles(2);
        vectors++;
        if (LED !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_led: got %h expected %h", LED, 20'h0);
        end
        vectors++;
        if (FRAME_ERR !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_err: got %b expected %b", FRAME_ERR, 1'b0);
        end
        RESET = 1'b0;
        waitCycles(4);
        vectors++;
        if (LED !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL idle_led: got %h expected %h", LED, 20'h0);
        end
        shiftBits(16'h001F, 5);
        RESET = 1'b1;
        waitCycles(2);
        vectors++;
        if (LED !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_led: got %h expected %h", LED, 20'h0);
        end
        RESET = 1'b0;
        sendFrame(16'h0021, 8);
        for (int i = 0; i < 16; i++) begin
            waitCycles(1);
            vectors++;
            if (LED !== 20'h00002) begin
                miscompares++;
                $display("[TB] FAIL post_reset_frame: got %h expected %h", LED, 20'h00002);
            end
        end
        vectors++;
        if (errCount !== 0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_err: got %0d expected %0d", errCount, 0);
        end
    endtask

    task automatic test_single_write();
        logic [19:0] exp;
        sendFrame(16'h001F, 8);
        sendFrame(16'h0045, 8);
        for (int i = 0; i < 48; i++) begin
            waitCycles(1);
            exp = '0;
            exp[5] = bA(cyc - 1);
            vectors++;
            if (LED !== exp) begin
                miscompares++;
                $display("[TB] FAIL single_write cyc=%0d: got %h expected %h", cyc, LED, exp);
            end
        end
        vectors++;
        if (errCount !== 0) begin
            miscompares++;
            $display("[TB] FAIL single_write_err: got %0d expected %0d", errCount, 0);
        end
    endtask

    task automatic test_broadcast();
        logic [19:0] exp;
        logic [19:0] prevLed;
        sendFrame(16'h007F, 8);
        sendFrame(16'h0040, 8);
        waitCycles(1);
        prevLed = LED;
        for (int i = 0; i < 64; i++) begin
            waitCycles(1);
            exp = bB(cyc - 1) ? 20'hFFFFE : 20'h00000;
            exp[0] = bA(cyc - 1);
            vectors++;
            if (LED !== exp) begin
                miscompares++;
                $display("[TB] FAIL broadcast cyc=%0d: got %h expected %h", cyc, LED, exp);
            end
            if (LED[19:1] !== prevLed[19:1]) begin
                vectors++;
                if ({prevLed[0], LED[0]} !== 2'b01) begin
                    miscompares++;
                    $display("[TB] FAIL half_rate_edge cyc=%0d: got led0 %b->%b expected 0->1",
                             cyc, prevLed[0], LED[0]);
                end
            end
            prevLed = LED;
        end
    endtask

    task automatic test_brightness();
        logic [19:0] exp;
        sendFrame(16'h003F, 8);
        sendFrame(16'h001E, 8);
        for (int i = 0; i < 24; i++) begin
            waitCycles(1);
            exp = (((cyc - 1) % 8) == 0) ? 20'hFFFFF : 20'h00000;
            vectors++;
            if (LED !== exp) begin
                miscompares++;
                $display("[TB] FAIL bright0 cyc=%0d: got %h expected %h", cyc, LED, exp);
            end
        end
        sendFrame(16'h00FE, 8);
        for (int i = 0; i < 16; i++) begin
            waitCycles(1);
            vectors++;
            if (LED !== 20'hFFFFF) begin
                miscompares++;
                $display("[TB] FAIL bright7 cyc=%0d: got %h expected %h", cyc, LED, 20'hFFFFF);
            end
        end
    endtask

    task automatic test_errors();
        int base;
        sendFrame(16'h001F, 8);
        sendFrame(16'h0023, 8);
        base = errCount;
        sendFrame(16'h0000, 7);
        vectors++;
        if (errCount !== base + 1) begin
            miscompares++;
            $display("[TB] FAIL err_7bit: got %0d expected %0d", errCount, base + 1);
        end
        for (int i = 0; i < 16; i++) begin
            waitCycles(1);
            vectors++;
            if (LED !== 20'h00008) begin
                miscompares++;
                $display("[TB] FAIL err_7bit_led: got %h expected %h", LED, 20'h00008);
            end
        end
        sendFrame(16'h0121, 9);
        vectors++;
        if (errCount !== base + 2) begin
            miscompares++;
            $display("[TB] FAIL err_9bit: got %0d expected %0d", errCount, base + 2);
        end
        vectors++;
        if (LED !== 20'h00008) begin
            miscompares++;
            $display("[TB] FAIL err_9bit_led: got %h expected %h", LED, 20'h00008);
        end
        sendFrame(16'h0034, 8);
        vectors++;
        if (errCount !== base + 3) begin
            miscompares++;
            $display("[TB] FAIL err_addr20: got %0d expected %0d", errCount, base + 3);
        end
        vectors++;
        if (LED !== 20'h00008) begin
            miscompares++;
            $display("[TB] FAIL err_addr20_led: got %h expected %h", LED, 20'h00008);
        end
        sendFrame(16'h0022, 8);
        vectors++;
        if (errCount !== base + 3) begin
            miscompares++;
            $display("[TB] FAIL err_recover_cnt: got %0d expected %0d", errCount, base + 3);
        end
        vectors++;
        if (LED !== 20'h0000C) begin
            miscompares++;
            $display("[TB] FAIL err_recover_led: got %h expected %h", LED, 20'h0000C);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        base = errCount;
        shiftBits(16'h0026, 8);
        DATA = 1'b1;
        waitCycles(4);
        SCLK = 1'b1;
        LATCH = 1'b1;
        waitCycles(4);
        SCLK = 1'b0;
        waitCycles(4);
        LATCH = 1'b0;
        waitCycles(4);
        vectors++;
        if (errCount !== base) begin
            miscompares++;
            $display("[TB] FAIL simul_err: got %0d expected %0d", errCount, base);
        end
        vectors++;
        if (LED !== 20'h0004C) begin
            miscompares++;
            $display("[TB] FAIL simul_led: got %h expected %h", LED, 20'h0004C);
        end
        sendFrame(16'h0027, 8);
        vectors++;
        if (errCount !== base) begin
            miscompares++;
            $display("[TB] FAIL simul_next_err: got %0d expected %0d", errCount, base);
        end
        vectors++;
        if (LED !== 20'h000CC) begin
            miscompares++;
            $display("[TB] FAIL simul_next_led: got %h expected %h", LED, 20'h000CC);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_broadcast();
        test_brightness();
        test_errors();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
